// File: rtl/valve_cmd_demux_pkg.sv
// Shared constants for the valve command demultiplexer: valve drive levels,
// the default hold time and the hold-counter width helper.
package valve_cmd_demux_pkg;

    localparam logic VALVE_OPEN       = 1'b1;
    localparam logic VALVE_CLOSED     = 1'b0;
    localparam int   DEFAULT_HOLD_CYC = 16;

    // Counter must be able to hold the value HOLD_CYC itself.
    function automatic int hold_cnt_w(input int hold_cyc);
        return (hold_cyc < 1) ? 1 : $clog2(hold_cyc + 1);
    endfunction

endpackage

// File: rtl/valve_cmd_demux_if.sv
// Command/status bundle between the control FSM (master) and the valve
// command demultiplexer (slave).
interface valve_cmd_demux_if #(
    parameter int N_CH  = 2,
    parameter int SEL_W = 1
);
    logic             din;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             ack;
    logic             err;
    logic [N_CH-1:0]  valve;
    logic [N_CH-1:0]  busy;

    modport master (output din, sel, valid, input ack, err, valve, busy);
    modport slave  (input din, sel, valid, output ack, err, valve, busy);
endinterface

// File: rtl/valve_hold_channel.sv
// One valve channel: latches the last requested state and only lets the valve
// output change when the minimum hold time since the previous change has expired.
module valve_hold_channel
    import valve_cmd_demux_pkg::*;
#(
    parameter int HOLD_CYC = DEFAULT_HOLD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic wr,
    input  logic d,
    output logic valve,
    output logic busy
);
    localparam int             CW   = hold_cnt_w(HOLD_CYC);
    localparam logic [CW-1:0]  HOLD = CW'(HOLD_CYC);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic          pending;
    logic [CW-1:0] cnt;
    logic          eff;

    // A command arriving this cycle overrides the stored request immediately.
    assign eff  = wr ? d : pending;
    assign busy = (cnt != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= VALVE_CLOSED;
            valve   <= VALVE_CLOSED;
            cnt     <= '0;
        end else begin
            if (wr)
                pending <= d;
            // cnt != 0 is LOCKED: valve frozen, requests only update pending.
            if (cnt != '0) begin
                cnt <= cnt - ONE;
            end else if (eff != valve) begin
                valve <= eff;
                cnt   <= HOLD;
            end
        end
    end

endmodule

// File: rtl/valve_cmd_demux.sv
// Distributes select-tagged valve commands to N_CH hold-protected channels and
// reports acceptance (ack) or an out-of-range select (err) one cycle later.
module valve_cmd_demux
    import valve_cmd_demux_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int SEL_W    = 1,
    parameter int HOLD_CYC = DEFAULT_HOLD_CYC
) (
    input logic               clk,
    input logic               rst,
    valve_cmd_demux_if.slave  bus
);
    // One extra bit so N_CH == 2**SEL_W is still representable.
    localparam logic [SEL_W:0] NCH_V = (SEL_W + 1)'(N_CH);

    logic            in_range;
    logic [N_CH-1:0] wr;

    assign in_range = ({1'b0, bus.sel} < NCH_V);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = bus.valid && (bus.sel == SEL_W'(i));

        valve_hold_channel #(
            .HOLD_CYC (HOLD_CYC)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr[i]),
            .d     (bus.din),
            .valve (bus.valve[i]),
            .busy  (bus.busy[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.ack <= bus.valid && in_range;
            bus.err <= bus.valid && !in_range;
        end
    end

endmodule

// File: tb/tb_valve_cmd_demux.sv
// Directed plus random stimulus against a spacing-based reference model,
// driving a 2-channel and a 3-channel (2-bit select) instance side by side.
module tb_valve_cmd_demux;
    import valve_cmd_demux_pkg::*;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    valve_cmd_demux_if #(.N_CH(2), .SEL_W(1)) bus2 ();
    valve_cmd_demux_if #(.N_CH(3), .SEL_W(2)) bus3 ();

    valve_cmd_demux #(.N_CH(2), .SEL_W(1), .HOLD_CYC(HOLD)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    valve_cmd_demux #(.N_CH(3), .SEL_W(2), .HOLD_CYC(HOLD)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a valve may change only if at least HOLD+1 edges have
    // passed since its last change; it is busy for HOLD edges after a change.
    int       t = 0;
    int       nch [2] = '{2, 3};
    logic     m_valve [2][3];
    logic     m_want  [2][3];
    int       m_last  [2][3];
    logic     m_ack   [2];
    logic     m_err   [2];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_valve_vec(input int m);
        logic [3:0] v = '0;
        for (int c = 0; c < nch[m]; c++) v[c] = m_valve[m][c];
        return v;
    endfunction

    function automatic logic [3:0] m_busy_vec(input int m);
        logic [3:0] b = '0;
        for (int c = 0; c < nch[m]; c++) b[c] = ((t - m_last[m][c]) < HOLD);
        return b;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [1:0] s, input logic d);
        int sel_m;
        t++;
        for (int m = 0; m < 2; m++) begin
            sel_m = (m == 0) ? int'(s[0]) : int'(s);
            if (r) begin
                m_ack[m] = 1'b0;
                m_err[m] = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    m_valve[m][c] = VALVE_CLOSED;
                    m_want[m][c]  = VALVE_CLOSED;
                    m_last[m][c]  = -1000;
                end
            end else begin
                m_ack[m] = v && (sel_m < nch[m]);
                m_err[m] = v && (sel_m >= nch[m]);
                for (int c = 0; c < nch[m]; c++) begin
                    if (v && sel_m == c) m_want[m][c] = d;
                    if ((t - m_last[m][c]) >= HOLD + 1 && m_want[m][c] != m_valve[m][c]) begin
                        m_valve[m][c] = m_want[m][c];
                        m_last[m][c]  = t;
                    end
                end
            end
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s, input logic d);
        rst        = r;
        bus2.valid = v;
        bus2.sel   = s[0];
        bus2.din   = d;
        bus3.valid = v;
        bus3.sel   = s;
        bus3.din   = d;
        @(posedge clk);
        model_edge(r, v, s, d);
        @(negedge clk);
        chk("ack2",   4'(bus2.ack),   4'(m_ack[0]));
        chk("err2",   4'(bus2.err),   4'(m_err[0]));
        chk("valve2", 4'(bus2.valve), m_valve_vec(0));
        chk("busy2",  4'(bus2.busy),  m_busy_vec(0));
        chk("ack3",   4'(bus3.ack),   4'(m_ack[1]));
        chk("err3",   4'(bus3.err),   4'(m_err[1]));
        chk("valve3", 4'(bus3.valve), m_valve_vec(1));
        chk("busy3",  4'(bus3.busy),  m_busy_vec(1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        bus2.valid = 1'b0; bus2.sel = '0; bus2.din = 1'b0;
        bus3.valid = 1'b0; bus3.sel = '0; bus3.din = 1'b0;
        @(negedge clk);

        // Reset held two cycles with an active command on the bus.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 2'd0, 1'b1);
            chk("rst_valve", 4'(bus2.valve), 4'h0);
            chk("rst_busy",  4'(bus2.busy),  4'h0);
            chk("rst_ack",   4'(bus2.ack),   4'h0);
        end

        // Basic open of channel 1.
        step(1'b0, 1'b1, 2'd1, 1'b1);
        chk("basic_ack",   4'(bus2.ack),   4'h1);
        chk("basic_valve", 4'(bus2.valve), 4'b0010);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("basic_busy", 4'(bus2.busy), 4'b0010);
        end
        idle(1);
        chk("basic_busy_end", 4'(bus2.busy), 4'b0000);

        // Hold: open ch0, immediately request close; close lands 5 cycles later.
        step(1'b0, 1'b1, 2'd0, 1'b1);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        chk("hold_c2", 4'(bus2.valve), 4'b0011);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("hold_frozen", 4'(bus2.valve), 4'b0011);
        end
        idle(1);
        chk("hold_c6", 4'(bus2.valve), 4'b0010);
        idle(4);

        // Last-write-wins: close then reopen during LOCKED yields no second change.
        step(1'b0, 1'b1, 2'd0, 1'b1);
        step(1'b0, 1'b1, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b1);
        idle(1);
        chk("lww_busy_c4", 4'(bus2.busy), 4'b0001);
        idle(1);
        chk("lww_busy_c5", 4'(bus2.busy), 4'b0000);
        idle(3);
        chk("lww_valve", 4'(bus2.valve), 4'b0011);
        chk("lww_busy",  4'(bus2.busy),  4'b0000);

        // Out-of-range select on the 3-channel instance.
        step(1'b0, 1'b1, 2'd3, 1'b1);
        chk("badsel_err", 4'(bus3.err), 4'h1);
        chk("badsel_ack", 4'(bus3.ack), 4'h0);

        // Reset in the middle of a hold with a close pending.
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 1'b1);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("rstmid_valve", 4'(bus2.valve), 4'h0);
        chk("rstmid_busy",  4'(bus2.busy),  4'h0);
        idle(8);
        chk("rstmid_later", 4'(bus2.valve), 4'h0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                 2'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
